// File: rtl/spit_pkg.sv
// spit_pkg: shared state type, widths and enemy_pos unpack helpers for the spit scheduler
package spit_pkg;
  typedef enum logic [1:0] {IDLE, PICK, ALLOC, FIRE} state_t;
  localparam int POS_W = 10;
  localparam int LFSR_W = 31;
  localparam int ENEMY_W = 2 * POS_W;
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [POS_W-1:0] pos_x(input logic [ENEMY_W-1:0] p);
    return p[ENEMY_W-1:POS_W];
  endfunction
  function automatic logic [POS_W-1:0] pos_y(input logic [ENEMY_W-1:0] p);
    return p[POS_W-1:0];
  endfunction
endpackage

// File: rtl/spit_slot_alloc.sv
// spit_slot_alloc: lowest-free-index priority encoder over slot occupancy
module spit_slot_alloc #(
  parameter int N = 30,
  parameter int W = 5
) (
  input  logic [N-1:0] busy,
  output logic         found,
  output logic [W-1:0] idx
);
  // scan from the top so the lowest free index is the last one written
  always_comb begin
    found = ~&busy;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = busy[i] ? idx : W'(i);
  end
endmodule

// File: rtl/spit_scheduler.sv
// spit_scheduler: periodic enemy fire controller claiming free spit slots (aiming under SPIT_SCHED_AIM_EN)
import spit_pkg::*;
module spit_scheduler #(
  parameter int          NUM_ENEMY   = 5,
  parameter int          NUM_SLOTS   = 30,
  parameter int          FIRE_PERIOD = 2000000,
  parameter logic [30:0] LFSR_SEED   = 31'd9249689,
  parameter int          SPAWN_DX    = 13,
  parameter int          SPAWN_DY    = 40
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [ENEMY_W*NUM_ENEMY-1:0] enemy_pos,
  input  logic [NUM_ENEMY-1:0]         enemy_dead,
`ifdef SPIT_SCHED_AIM_EN
  input  logic [POS_W-1:0]             player_x,
`endif
  input  logic [NUM_SLOTS-1:0]         slot_done,
  output logic [NUM_SLOTS-1:0]         fire,
  output logic [POS_W-1:0]             fire_x,
  output logic [POS_W-1:0]             fire_y,
`ifdef SPIT_SCHED_AIM_EN
  output logic signed [1:0]            fire_vx,
`endif
  output logic [NUM_SLOTS-1:0]         busy,
  output logic [7:0]                   drop_count
);
  localparam int EW = slot_w(NUM_ENEMY);
  localparam int SW = slot_w(NUM_SLOTS);
  localparam int CW = $clog2(FIRE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(FIRE_PERIOD - 1);
  state_t state;
  logic [LFSR_W-1:0] lfsr;
  logic [CW-1:0] cnt;
  logic [EW-1:0] cand, eidx, cand_first, cand_next;
  logic [6:0] probes;
  logic [ENEMY_W-1:0] epos;
  logic [POS_W-1:0] sx, sy;
  logic [7:0] drop_inc;
  logic tick, found;
  logic [SW-1:0] idx;
`ifdef SPIT_SCHED_AIM_EN
  logic signed [1:0] vx;
`endif
  spit_slot_alloc #(.N(NUM_SLOTS), .W(SW)) u_alloc (.busy(busy), .found(found), .idx(idx));
  // tick, candidate stepping and spawn position of the latched enemy
  always_comb begin
    tick = enable && cnt == LAST;
    cand_first = EW'(lfsr[6:0] % 7'(NUM_ENEMY));
    cand_next = (cand == EW'(NUM_ENEMY - 1)) ? '0 : cand + EW'(1);
    epos = enemy_pos[int'(eidx)*ENEMY_W +: ENEMY_W];
    sx = pos_x(epos) + POS_W'(SPAWN_DX);
    sy = pos_y(epos) + POS_W'(SPAWN_DY);
    drop_inc = (drop_count == 8'hff) ? drop_count : drop_count + 8'd1;
`ifdef SPIT_SCHED_AIM_EN
    vx = (player_x > sx) ? 2'sb01 : (player_x < sx) ? 2'sb11 : 2'sb00;
`endif
  end
  // lfsr, period counter, occupancy and the pick/alloc/fire sequence
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      cnt <= '0;
      cand <= '0;
      eidx <= '0;
      probes <= '0;
      fire <= '0;
      busy <= '0;
      fire_x <= '0;
      fire_y <= '0;
      drop_count <= '0;
`ifdef SPIT_SCHED_AIM_EN
      fire_vx <= '0;
`endif
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[30] ^ lfsr[27]};
      cnt <= (!enable || cnt == LAST) ? '0 : cnt + CW'(1);
      busy <= (busy & ~slot_done) | fire;
      fire <= '0;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= PICK;
            cand <= cand_first;
            probes <= '0;
          end
        end
        PICK: begin
          if (!enable) state <= IDLE;
          else if (!enemy_dead[cand]) begin
            eidx <= cand;
            state <= ALLOC;
          end else if (probes == 7'(NUM_ENEMY - 1)) begin
            drop_count <= drop_inc;
            state <= IDLE;
          end else begin
            cand <= cand_next;
            probes <= probes + 7'd1;
          end
        end
        ALLOC: begin
          if (!enable) state <= IDLE;
          else if (!found) begin
            drop_count <= drop_inc;
            state <= IDLE;
          end else begin
            fire <= NUM_SLOTS'(1) << idx;
            fire_x <= sx;
            fire_y <= sy;
`ifdef SPIT_SCHED_AIM_EN
            fire_vx <= vx;
`endif
            state <= FIRE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
